// File: rtl/cmos_frame_bank_ctrl_pkg.sv
// rtl/cmos_frame_bank_ctrl_pkg.sv - shared types and defaults for the frame bank controller
package cmos_frame_bank_ctrl_pkg;

  localparam int FRAME_PIXELS_DEF = 307200;
  localparam int ADDR_W_DEF       = 19;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARM     = 2'd1,
    CAP_CAPTURE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/cmos_bank_tracker.sv
// rtl/cmos_bank_tracker.sv - two-bank state tracker with age order and claim/release
module cmos_bank_tracker
  import cmos_frame_bank_ctrl_pkg::*;
(
  input  logic cam_pclk,
  input  logic rst_n,
  input  logic fill_done_ok,
  input  logic fill_done_bad,
  input  logic fill_bank,
  input  logic alloc_req,
  output logic alloc_ok,
  output logic alloc_bank,
  input  logic rd_claim,
  input  logic rd_release,
  output logic frame_ready,
  output logic rd_bank,
  output logic rd_busy
);

  bank_state_t bank_q   [0:1];
  bank_state_t bank_mid [0:1];
  bank_state_t bank_d   [0:1];
  logic        oldest_q;
  logic        oldest_d;
  logic        busy_d;
  logic        ready_d;
  logic        rd_bank_d;
  logic        full0_d;
  logic        full1_d;

  // Release and frame completion resolve first so a freed bank is allocatable the same cycle
  always_comb begin
    bank_mid = bank_q;
    if (rd_release && rd_busy) begin
      for (int b = 0; b < 2; b++) begin
        if (bank_mid[b] == BANK_READING) bank_mid[b] = BANK_EMPTY;
      end
    end
    if (fill_done_ok) begin
      bank_mid[fill_bank] = BANK_FULL;
    end else if (fill_done_bad) begin
      bank_mid[fill_bank] = BANK_EMPTY;
    end
  end

  assign alloc_ok   = (bank_mid[0] == BANK_EMPTY) || (bank_mid[1] == BANK_EMPTY);
  assign alloc_bank = (bank_mid[0] == BANK_EMPTY) ? 1'b0 : 1'b1;

  // Claim acts on the previously presented bank; allocation picks the lowest EMPTY bank
  always_comb begin
    bank_d = bank_mid;
    if (rd_claim && frame_ready && !rd_busy) bank_d[rd_bank] = BANK_READING;
    if (alloc_req && alloc_ok) bank_d[alloc_bank] = BANK_FILLING;
    oldest_d = oldest_q;
    if (fill_done_ok && (bank_d[!fill_bank] != BANK_FULL)) oldest_d = fill_bank;
    busy_d  = (bank_d[0] == BANK_READING) || (bank_d[1] == BANK_READING);
    full0_d = (bank_d[0] == BANK_FULL);
    full1_d = (bank_d[1] == BANK_FULL);
    ready_d = (full0_d || full1_d) && !busy_d;
    if (busy_d) begin
      rd_bank_d = (bank_d[1] == BANK_READING);
    end else if (full0_d && full1_d) begin
      rd_bank_d = oldest_d;
    end else begin
      rd_bank_d = full1_d;
    end
  end

  // Bank states, age bit and registered consumer-facing outputs
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]   <= BANK_EMPTY;
      bank_q[1]   <= BANK_EMPTY;
      oldest_q    <= 1'b0;
      frame_ready <= 1'b0;
      rd_bank     <= 1'b0;
      rd_busy     <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      oldest_q    <= oldest_d;
      frame_ready <= ready_d;
      rd_bank     <= rd_bank_d;
      rd_busy     <= busy_d;
    end
  end

endmodule

// File: rtl/cmos_frame_bank_ctrl.sv
// rtl/cmos_frame_bank_ctrl.sv - ping-pong frame bank controller between capture and BRAM
module cmos_frame_bank_ctrl
  import cmos_frame_bank_ctrl_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic              cam_pclk,
  input  logic              rst_n,
  input  logic              capture_en,
  input  logic              cmos_pos_vsync,
  input  logic              cmos_frame_valid,
  input  logic [15:0]       cmos_frame_data,
  output logic              bram_wr_en,
  output logic [ADDR_W:0]   bram_wr_addr,
  output logic [15:0]       bram_wr_data,
  output logic              frame_ready,
  output logic              rd_bank,
  input  logic              rd_claim,
  output logic              rd_busy,
  input  logic              rd_release,
  output logic              frame_err,
  output logic [15:0]       frames_done,
  output logic [7:0]        frames_dropped
);

  localparam logic [ADDR_W:0] FRAME_CNT = (ADDR_W + 1)'(FRAME_PIXELS);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

  cap_state_t      state_q;
  logic            wr_bank_q;
  logic [ADDR_W:0] pix_cnt_q;
  logic            overrun_q;

  logic frame_end;
  logic frame_ok;
  logic frame_bad;
  logic arm_eval;
  logic alloc_ok;
  logic alloc_bank;
  logic alloc_req;
  logic pix_accept;

  // A vsync both closes the current frame and opens the next one in the same cycle
  assign frame_end  = cmos_pos_vsync && (state_q == CAP_CAPTURE);
  assign frame_ok   = frame_end && (pix_cnt_q == FRAME_CNT) && !overrun_q;
  assign frame_bad  = frame_end && !frame_ok;
  assign arm_eval   = cmos_pos_vsync && capture_en;
  assign alloc_req  = arm_eval && alloc_ok;
  assign pix_accept = (state_q == CAP_CAPTURE) && cmos_frame_valid && !cmos_pos_vsync;

  cmos_bank_tracker u_tracker (
    .cam_pclk      (cam_pclk),
    .rst_n         (rst_n),
    .fill_done_ok  (frame_ok),
    .fill_done_bad (frame_bad),
    .fill_bank     (wr_bank_q),
    .alloc_req     (alloc_req),
    .alloc_ok      (alloc_ok),
    .alloc_bank    (alloc_bank),
    .rd_claim      (rd_claim),
    .rd_release    (rd_release),
    .frame_ready   (frame_ready),
    .rd_bank       (rd_bank),
    .rd_busy       (rd_busy)
  );

  // Capture FSM, pixel write path and frame statistics
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= CAP_IDLE;
      wr_bank_q      <= 1'b0;
      pix_cnt_q      <= '0;
      overrun_q      <= 1'b0;
      bram_wr_en     <= 1'b0;
      bram_wr_addr   <= '0;
      bram_wr_data   <= '0;
      frame_err      <= 1'b0;
      frames_done    <= '0;
      frames_dropped <= '0;
    end else begin
      bram_wr_en <= 1'b0;
      frame_err  <= frame_bad;
      if (frame_ok) frames_done <= frames_done + 16'd1;
      if (arm_eval && !alloc_ok && (frames_dropped != 8'hFF)) begin
        frames_dropped <= frames_dropped + 8'd1;
      end
      if (pix_accept) begin
        if (pix_cnt_q < FRAME_CNT) begin
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= {wr_bank_q, pix_cnt_q[ADDR_W-1:0]};
          bram_wr_data <= cmos_frame_data;
          pix_cnt_q    <= pix_cnt_q + CNT_ONE;
        end else begin
          overrun_q <= 1'b1;
        end
      end
      if (cmos_pos_vsync) begin
        if (!capture_en) begin
          state_q <= CAP_IDLE;
        end else if (alloc_ok) begin
          state_q   <= CAP_CAPTURE;
          wr_bank_q <= alloc_bank;
          pix_cnt_q <= '0;
          overrun_q <= 1'b0;
        end else begin
          state_q <= CAP_ARM;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_frame_bank_ctrl.sv
// tb/tb_cmos_frame_bank_ctrl.sv - directed self-checking bench for cmos_frame_bank_ctrl
module tb_cmos_frame_bank_ctrl;

  localparam int FP = 16;
  localparam int AW = 5;

  logic          cam_pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          capture_en = 1'b0;
  logic          cmos_pos_vsync = 1'b0;
  logic          cmos_frame_valid = 1'b0;
  logic [15:0]   cmos_frame_data = 16'h0;
  logic          bram_wr_en;
  logic [AW:0]   bram_wr_addr;
  logic [15:0]   bram_wr_data;
  logic          frame_ready;
  logic          rd_bank;
  logic          rd_claim = 1'b0;
  logic          rd_busy;
  logic          rd_release = 1'b0;
  logic          frame_err;
  logic [15:0]   frames_done;
  logic [7:0]    frames_dropped;

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  logic [15:0] wmem [0:63];

  cmos_frame_bank_ctrl #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
    .cam_pclk         (cam_pclk),
    .rst_n            (rst_n),
    .capture_en       (capture_en),
    .cmos_pos_vsync   (cmos_pos_vsync),
    .cmos_frame_valid (cmos_frame_valid),
    .cmos_frame_data  (cmos_frame_data),
    .bram_wr_en       (bram_wr_en),
    .bram_wr_addr     (bram_wr_addr),
    .bram_wr_data     (bram_wr_data),
    .frame_ready      (frame_ready),
    .rd_bank          (rd_bank),
    .rd_claim         (rd_claim),
    .rd_busy          (rd_busy),
    .rd_release       (rd_release),
    .frame_err        (frame_err),
    .frames_done      (frames_done),
    .frames_dropped   (frames_dropped)
  );

  always #5 cam_pclk = ~cam_pclk;

  // Record every BRAM write away from the active edge
  always @(negedge cam_pclk) begin
    if (bram_wr_en) begin
      wmem[bram_wr_addr] = bram_wr_data;
      wr_count = wr_count + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cam_pclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    capture_en = 1'b0;
    cmos_pos_vsync = 1'b0;
    cmos_frame_valid = 1'b0;
    cmos_frame_data = 16'h0;
    rd_claim = 1'b0;
    rd_release = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    wr_count = 0;
    for (int i = 0; i < 64; i++) wmem[i] = 16'hDEAD;
  endtask

  task automatic vsync();
    cmos_pos_vsync = 1'b1;
    tick();
    cmos_pos_vsync = 1'b0;
  endtask

  task automatic send_pixels(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      cmos_frame_valid = 1'b1;
      cmos_frame_data = base + 16'(i);
      tick();
    end
    cmos_frame_valid = 1'b0;
  endtask

  task automatic pulse_claim();
    rd_claim = 1'b1;
    tick();
    rd_claim = 1'b0;
  endtask

  task automatic pulse_release();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  initial begin
    do_reset();
    check_val("rst_wr_en", 32'(bram_wr_en), 32'd0);
    check_val("rst_wr_addr", 32'(bram_wr_addr), 32'd0);
    check_val("rst_wr_data", 32'(bram_wr_data), 32'd0);
    check_val("rst_ready", 32'(frame_ready), 32'd0);
    check_val("rst_rd_bank", 32'(rd_bank), 32'd0);
    check_val("rst_busy", 32'(rd_busy), 32'd0);
    check_val("rst_err", 32'(frame_err), 32'd0);
    check_val("rst_done", 32'(frames_done), 32'd0);
    check_val("rst_dropped", 32'(frames_dropped), 32'd0);

    // Three frames, no claims: banks 0 and 1 fill, third is dropped
    capture_en = 1'b1;
    vsync();
    send_pixels(16, 16'h1000);
    vsync();
    check_val("s1_done1", 32'(frames_done), 32'd1);
    check_val("s1_ready1", 32'(frame_ready), 32'd1);
    check_val("s1_rdbank1", 32'(rd_bank), 32'd0);
    check_val("s1_err1", 32'(frame_err), 32'd0);
    send_pixels(16, 16'h2000);
    vsync();
    check_val("s1_done2", 32'(frames_done), 32'd2);
    check_val("s1_dropped", 32'(frames_dropped), 32'd1);
    check_val("s1_ready2", 32'(frame_ready), 32'd1);
    check_val("s1_rdbank2", 32'(rd_bank), 32'd0);
    check_val("s1_wr_count", 32'(wr_count), 32'd32);
    for (int i = 0; i < 16; i++) begin
      check_val("s1_b0_data", 32'(wmem[i]), 32'h1000 + 32'(i));
      check_val("s1_b1_data", 32'(wmem[32 + i]), 32'h2000 + 32'(i));
    end
    send_pixels(16, 16'h2800);
    tick();
    check_val("s1_armed_no_write", 32'(wr_count), 32'd32);

    // Claim and release the older bank, then the remaining one
    pulse_claim();
    check_val("s2_busy", 32'(rd_busy), 32'd1);
    check_val("s2_rdbank_claimed", 32'(rd_bank), 32'd0);
    check_val("s2_ready_while_busy", 32'(frame_ready), 32'd0);
    tick();
    check_val("s2_busy_hold", 32'(rd_busy), 32'd1);
    pulse_release();
    check_val("s2_busy_rel", 32'(rd_busy), 32'd0);
    check_val("s2_ready_b1", 32'(frame_ready), 32'd1);
    check_val("s2_rdbank_b1", 32'(rd_bank), 32'd1);
    pulse_claim();
    check_val("s2_busy_b1", 32'(rd_busy), 32'd1);
    check_val("s2_rdbank_b1c", 32'(rd_bank), 32'd1);
    pulse_release();
    check_val("s2_ready_none", 32'(frame_ready), 32'd0);
    check_val("s2_busy_none", 32'(rd_busy), 32'd0);
    wr_count = 0;
    vsync();
    send_pixels(16, 16'h5000);
    vsync();
    check_val("s2_refill_b0", 32'(wmem[0]), 32'h5000);
    check_val("s2_refill_rdbank", 32'(rd_bank), 32'd0);
    check_val("s2_refill_done", 32'(frames_done), 32'd3);

    // Short frame then long frame: both discarded
    do_reset();
    capture_en = 1'b1;
    vsync();
    send_pixels(15, 16'h3100);
    vsync();
    check_val("s3_err_short", 32'(frame_err), 32'd1);
    check_val("s3_done_short", 32'(frames_done), 32'd0);
    check_val("s3_ready_short", 32'(frame_ready), 32'd0);
    tick();
    check_val("s3_err_pulse_end", 32'(frame_err), 32'd0);
    send_pixels(17, 16'h3000);
    tick();
    check_val("s3_wr_count", 32'(wr_count), 32'd31);
    check_val("s3_last_addr", 32'(bram_wr_addr), 32'h0F);
    check_val("s3_last_data", 32'(wmem[15]), 32'h300F);
    vsync();
    check_val("s3_err_long", 32'(frame_err), 32'd1);
    check_val("s3_done_long", 32'(frames_done), 32'd0);
    check_val("s3_ready_long", 32'(frame_ready), 32'd0);
    check_val("s3_dropped", 32'(frames_dropped), 32'd0);

    // Release coincident with vsync while bank 0 is read and bank 1 fills
    do_reset();
    capture_en = 1'b1;
    vsync();
    send_pixels(16, 16'h4100);
    vsync();
    pulse_claim();
    check_val("s4_busy", 32'(rd_busy), 32'd1);
    send_pixels(16, 16'h4200);
    rd_release = 1'b1;
    vsync();
    rd_release = 1'b0;
    check_val("s4_dropped0", 32'(frames_dropped), 32'd0);
    check_val("s4_done", 32'(frames_done), 32'd2);
    check_val("s4_busy_rel", 32'(rd_busy), 32'd0);
    check_val("s4_ready", 32'(frame_ready), 32'd1);
    check_val("s4_rdbank", 32'(rd_bank), 32'd1);
    send_pixels(16, 16'h4000);
    vsync();
    check_val("s4_b0_first", 32'(wmem[0]), 32'h4000);
    check_val("s4_b0_last", 32'(wmem[15]), 32'h400F);
    check_val("s4_done3", 32'(frames_done), 32'd3);
    check_val("s4_oldest", 32'(rd_bank), 32'd1);
    check_val("s4_dropped1", 32'(frames_dropped), 32'd1);

    // capture_en dropped mid-frame: frame still publishes, then idle
    do_reset();
    capture_en = 1'b1;
    vsync();
    send_pixels(8, 16'h5500);
    capture_en = 1'b0;
    send_pixels(8, 16'h5508);
    vsync();
    check_val("s5_done", 32'(frames_done), 32'd1);
    check_val("s5_ready", 32'(frame_ready), 32'd1);
    check_val("s5_err", 32'(frame_err), 32'd0);
    wr_count = 0;
    send_pixels(16, 16'h5600);
    vsync();
    tick();
    check_val("s5_no_writes", 32'(wr_count), 32'd0);
    check_val("s5_done_hold", 32'(frames_done), 32'd1);
    check_val("s5_dropped", 32'(frames_dropped), 32'd0);

    // Asynchronous reset mid-capture with a bank claimed
    do_reset();
    capture_en = 1'b1;
    vsync();
    send_pixels(16, 16'h6100);
    vsync();
    pulse_claim();
    send_pixels(5, 16'h6200);
    check_val("s6_busy_pre", 32'(rd_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("s6_busy_rst", 32'(rd_busy), 32'd0);
    check_val("s6_done_rst", 32'(frames_done), 32'd0);
    check_val("s6_wr_en_rst", 32'(bram_wr_en), 32'd0);
    check_val("s6_addr_rst", 32'(bram_wr_addr), 32'd0);
    check_val("s6_ready_rst", 32'(frame_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) wmem[i] = 16'hDEAD;
    vsync();
    send_pixels(16, 16'h6000);
    vsync();
    check_val("s6_b0_first", 32'(wmem[0]), 32'h6000);
    check_val("s6_b0_last", 32'(wmem[15]), 32'h600F);
    check_val("s6_b1_untouched", 32'(wmem[32]), 32'hDEAD);
    check_val("s6_done", 32'(frames_done), 32'd1);
    check_val("s6_rdbank", 32'(rd_bank), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmos_frame_bank_ctrl.md
# cmos_frame_bank_ctrl

Double-buffer (ping-pong) controller between the CMOS capture datapath and the frame BRAM. The block owns two frame banks, steers capture writes into a free bank, publishes complete frames to the recognition consumer through a claim/release handshake, and drops camera frames when no bank is free. It runs in the camera pixel-clock domain, directly downstream of the 8→16-bit capture stage.

## Interface
- FRAME_PIXELS, 307200: 16-bit pixels per complete frame
- ADDR_W, 19: per-bank pixel address width; must satisfy 2^ADDR_W ≥ FRAME_PIXELS
- cam_pclk  in  1  pixel clock, the only clock
- rst_n  in  1  asynchronous active-low reset
- capture_en  in  1  level; sampled only on cmos_pos_vsync
- cmos_pos_vsync  in  1  one-cycle start-of-frame pulse
- cmos_frame_valid  in  1  one-cycle pixel strobe
- cmos_frame_data  in  16  RGB565 pixel
- bram_wr_en  out  1  BRAM write strobe
- bram_wr_addr  out  ADDR_W+1  {bank, pixel index}
- bram_wr_data  out  16  pixel
- frame_ready  out  1  a FULL bank is waiting to be claimed
- rd_bank  out  1  bank to claim/read; oldest FULL bank, or the claimed bank while rd_busy
- rd_claim  in  1  pulse; claims rd_bank; ignored unless frame_ready and !rd_busy
- rd_busy  out  1  a bank is claimed by the consumer
- rd_release  in  1  pulse; frees the claimed bank; ignored unless rd_busy
- frame_err  out  1  one-cycle pulse: captured frame discarded (short or long)
- frames_done  out  16  count of frames published, wraps
- frames_dropped  out  8  count of camera frames skipped for lack of a free bank, saturates at 255

## Operation
- Bank states: EMPTY, FILLING, FULL, READING. At most one FILLING, at most one READING.
- Capture FSM: IDLE, ARM, CAPTURE.
  - IDLE: on vsync with capture_en=1 → ARM behaviour evaluated the same cycle.
  - ARM: on vsync, if an EMPTY bank exists → mark it FILLING, clear pixel counter, → CAPTURE (lowest-numbered EMPTY bank chosen); else frames_dropped++ and stay ARM.
  - CAPTURE: each cmos_frame_valid writes data at {wr_bank, pix_cnt}, pix_cnt++. When pix_cnt == FRAME_PIXELS, further strobes are not written and set an overrun flag.
  - On next vsync: if pix_cnt == FRAME_PIXELS and no overrun → bank FULL, frames_done++, age order updated; else bank EMPTY, frame_err pulse. Then if capture_en=0 → IDLE; else re-evaluate ARM rule in the same cycle (back-to-back capture with no lost frame).
- Consumer: frame_ready = any FULL bank and !rd_busy. rd_claim → that bank READING, rd_busy=1. rd_release → READING bank EMPTY, rd_busy=0.
- With both banks FULL the older one is presented first.

## Timing
- Reset values: all outputs 0; both banks EMPTY; FSM IDLE; counters 0.
- BRAM write: registered, 1 cycle after cmos_frame_valid (addr/data/en aligned).
- frame_ready, rd_bank, rd_busy: registered, valid the cycle after the causing event (vsync completion, claim, release).
- frame_err, frames_done/dropped update: 1 cycle after the vsync.
- Simultaneous vsync and cmos_frame_valid: pixel ignored (blanking).
- Simultaneous rd_release and vsync: release applied first; the freed bank is eligible for that vsync.
- Simultaneous frame completion and rd_claim: claim acts on state before the vsync; the newly FULL bank becomes ready next cycle.
- Reset mid-frame or mid-read: all state cleared; consumer must treat rd_busy=0 as loss of claim.

## Structure
- Shared package: bank-state enum, capture FSM enum, FRAME_PIXELS default.
- One sub-module: cmos_bank_tracker (two bank-state registers, age bit, EMPTY/FULL selection, claim/release logic). Capture FSM and write path stay in the top.

## Test plan (bench uses FRAME_PIXELS=16, ADDR_W=5)
- Reset, capture_en=1, 3 vsync-bounded frames of 16 pixels, no claims -> frames 1,2 into banks 0,1, frames_done=2, 3rd frame dropped, frames_dropped=1, frame_ready=1, rd_bank=0.
- Frame of 16 pixels then claim/release -> writes addr 0x00–0x0F data matches, rd_busy high between claim and release, bank 0 EMPTY after release.
- Frame with 15 pixels, then one with 17 -> frame_err pulsed twice, frames_done=0, no bank FULL, pixel 17 not written.
- rd_release on same cycle as vsync with both banks busy -> released bank captures that frame, frames_dropped unchanged.
- capture_en dropped mid-frame -> current frame completes and publishes, FSM IDLE, no further writes.
- rst_n asserted mid-capture with bank claimed -> all outputs 0 immediately; next frame captures into bank 0.
